// File: rtl/cosim_chk_pkg.sv
// rtl/cosim_chk_pkg.sv - shared types and default sizing for the co-simulation result checker
//
// Holds the checker FSM state type and the default bus/counter widths and
// run length used by cosim_result_checker and its sub-modules.

package cosim_chk_pkg;

    // Checker run state: waiting for start, collecting samples, verdict held.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } chk_state_e;

    // Default width of the compared golden/netlist output buses.
    localparam int DEF_DATA_W      = 32;
    // Default width of the sample and mismatch counters.
    localparam int DEF_CNT_W       = 16;
    // Default samples per run: 1 reset check, 100 random, 1 corner case.
    localparam int DEF_NUM_SAMPLES = 102;

endpackage : cosim_chk_pkg

// File: rtl/cosim_sat_counter.sv
// rtl/cosim_sat_counter.sv - saturating up-counter with synchronous clear
//
// Ports:
//   clk  - clock, counter updates on rising edge
//   rst  - asynchronous active-low reset, forces the count to 0
//   clr  - synchronous clear, wins over inc
//   inc  - increment enable; the count holds once it reaches all-ones
//   cnt  - current count value

module cosim_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic at_max;

    assign at_max = &cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule : cosim_sat_counter

// File: rtl/cosim_result_checker.sv
// rtl/cosim_result_checker.sv - golden vs netlist output comparator with run statistics and verdict
//
// Ports:
//   clk              - clock, all state on rising edge
//   rst              - asynchronous active-low reset
//   start            - one-cycle pulse, begins a run and clears statistics (ignored while running)
//   sample_vld       - compare strobe, honoured only while running
//   golden_data      - golden model output bus
//   netlist_data     - netlist output bus
//   busy             - run in progress
//   done             - verdict available
//   pass             - done with zero mismatches
//   fail             - done with at least one mismatch
//   mm_pulse         - one-cycle pulse the cycle after a mismatching sample
//   sample_cnt       - samples accepted this run
//   mismatch_cnt     - mismatching samples this run, saturating
//   first_mm_idx     - 0-based index of the first mismatching sample
//   first_mm_golden  - golden value of the first mismatching sample
//   first_mm_netlist - netlist value of the first mismatching sample
//   first_mm_vld     - first-mismatch capture registers hold valid data

module cosim_result_checker
    import cosim_chk_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int NUM_SAMPLES = DEF_NUM_SAMPLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sample_vld,
    input  logic [DATA_W-1:0] golden_data,
    input  logic [DATA_W-1:0] netlist_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              mm_pulse,
    output logic [CNT_W-1:0]  sample_cnt,
    output logic [CNT_W-1:0]  mismatch_cnt,
    output logic [CNT_W-1:0]  first_mm_idx,
    output logic [DATA_W-1:0] first_mm_golden,
    output logic [DATA_W-1:0] first_mm_netlist,
    output logic              first_mm_vld
);

    // The sample counter must be able to represent NUM_SAMPLES without
    // saturating, otherwise the run would never reach DONE.
    if ((NUM_SAMPLES < 1) || (NUM_SAMPLES > ((2 ** CNT_W) - 1))) begin : g_bad_num_samples
        $error("cosim_result_checker: NUM_SAMPLES must be in 1..2^CNT_W-1");
    end

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SAMPLES - 1);

    chk_state_e state, state_nxt;

    logic run_start;   // start that actually opens a new run
    logic accept;      // sample counted this cycle
    logic mismatch;    // accepted sample differs
    logic last_sample; // accepted sample completes the run

    // A start during RUN is dropped, and a sample in the start cycle is not
    // counted because state is not yet RUN.
    assign run_start   = start && (state != ST_RUN);
    assign accept      = sample_vld && (state == ST_RUN);
    assign mismatch    = accept && (golden_data != netlist_data);
    assign last_sample = accept && (sample_cnt == LAST_IDX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start)       state_nxt = ST_RUN;
            ST_RUN:  if (last_sample) state_nxt = ST_DONE;
            ST_DONE: if (start)       state_nxt = ST_RUN;
            default:                  state_nxt = ST_IDLE;
        endcase
    end

    cosim_sat_counter #(.CNT_W(CNT_W)) u_sample_cnt (
        .clk (clk),
        .rst (rst),
        .clr (run_start),
        .inc (accept),
        .cnt (sample_cnt)
    );

    cosim_sat_counter #(.CNT_W(CNT_W)) u_mismatch_cnt (
        .clk (clk),
        .rst (rst),
        .clr (run_start),
        .inc (mismatch),
        .cnt (mismatch_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mm_pulse <= 1'b0;
        end else begin
            mm_pulse <= mismatch;
        end
    end

    // First-mismatch capture; sample_cnt is still the pre-increment value,
    // which is the 0-based index of the sample being compared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first_mm_vld     <= 1'b0;
            first_mm_idx     <= '0;
            first_mm_golden  <= '0;
            first_mm_netlist <= '0;
        end else if (run_start) begin
            first_mm_vld     <= 1'b0;
            first_mm_idx     <= '0;
            first_mm_golden  <= '0;
            first_mm_netlist <= '0;
        end else if (mismatch && !first_mm_vld) begin
            first_mm_vld     <= 1'b1;
            first_mm_idx     <= sample_cnt;
            first_mm_golden  <= golden_data;
            first_mm_netlist <= netlist_data;
        end
    end

    // Counters and state move on the same edge, so the verdict already
    // includes the final sample when done rises.
    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);
    assign pass = done && (mismatch_cnt == '0);
    assign fail = done && (mismatch_cnt != '0);

endmodule : cosim_result_checker

// File: doc/cosim_result_checker.md
Name: cosim_result_checker

Overview:
- Synthesizable checker placed directly downstream of a golden/netlist design pair in the co-simulation flow.
- Consumes the golden output bus and the netlist output bus on a sample strobe and compares them.
- Keeps sample and mismatch counts and captures the first mismatch.
- Issues a pass/fail verdict after a programmed number of samples; the same verdict logic can run in emulation or in a self-checking netlist bench.

Parameters:
- DATA_W, 32, width of the compared output buses.
- CNT_W, 16, width of the sample and mismatch counters.
- NUM_SAMPLES, 102, samples per run: 1 reset check, 100 random, 1 corner case.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a run and clears all statistics.
- sample_vld  input  1  compare strobe; golden_data and netlist_data are valid this cycle.
- golden_data  input  DATA_W  golden model output.
- netlist_data  input  DATA_W  post-synth/post-route netlist output.
- busy  output  1  high while in RUN.
- done  output  1  high in DONE state.
- pass  output  1  done with zero mismatches.
- fail  output  1  done with at least one mismatch.
- mm_pulse  output  1  one-cycle pulse, registered, one cycle after a mismatching sample.
- sample_cnt  output  CNT_W  samples accepted this run.
- mismatch_cnt  output  CNT_W  mismatches this run; saturates at all-ones.
- first_mm_idx  output  CNT_W  sample index (0-based) of the first mismatch.
- first_mm_golden  output  DATA_W  golden value at the first mismatch.
- first_mm_netlist  output  DATA_W  netlist value at the first mismatch.
- first_mm_vld  output  1  first-mismatch capture registers hold valid data.

Behaviour:
- Reset (rst low, asynchronous):
  - FSM to IDLE.
  - All outputs and counters 0, including the first_mm_* registers.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start.
  - RUN -> DONE on the cycle the accepted sample makes sample_cnt equal NUM_SAMPLES.
  - DONE -> RUN on start.
  - No other transitions.
- On entry to RUN (the start cycle):
  - sample_cnt, mismatch_cnt, first_mm_vld, first_mm_idx and first_mm_golden/netlist clear to 0.
  - pass, fail and done drop.
- start while in RUN is ignored; the run is not restarted.
- sample_vld is honoured only in RUN.
  - Ignored in IDLE and DONE.
  - Ignored in the same cycle as the start that leaves IDLE/DONE; the first counted sample is the cycle after start.
- For each accepted sample:
  - Compare full DATA_W with bitwise inequality.
  - sample_cnt increments.
  - On inequality:
    - mismatch_cnt increments, saturating at 2^CNT_W-1.
    - mm_pulse asserts for exactly the next cycle.
    - If first_mm_vld is 0: capture the pre-increment sample_cnt into first_mm_idx, capture both data buses, and set first_mm_vld.
- Latency: all outputs are registered and reflect a sample one cycle after its sample_vld edge.
- Final sample:
  - Counter update and the transition to DONE occur on the same edge.
  - done, pass and fail become valid together, and already include the final sample's result.
- pass = done & (mismatch_cnt == 0); fail = done & (mismatch_cnt != 0); mutually exclusive.
- Sample counter overflow: NUM_SAMPLES must be ≤ 2^CNT_W-1; this is checked by an elaboration-time assertion.
- A mid-run reset abandons the run with no residual state.
- busy = (state == RUN).

Decomposition:
- Shared package cosim_chk_pkg holds:
  - the state enum typedef (IDLE/RUN/DONE);
  - the default DATA_W, CNT_W and NUM_SAMPLES constants.
- One natural sub-module: cosim_sat_counter (CNT_W-wide, synchronous clear, increment enable, saturates at all-ones). It is instantiated twice: sample count (never reaching saturation) and mismatch count.

Test Plan:
- Reset and idle:
  - Assert rst low mid-cycle; all outputs read 0 immediately (asynchronous reset).
  - Pulse sample_vld 5× in IDLE; sample_cnt stays 0.
- All match:
  - start, then 102 samples with golden=netlist=random values.
  - done=1, pass=1, fail=0, mismatch_cnt=0, first_mm_vld=0 on the edge after sample 101; busy drops the same edge.
- Mismatch capture:
  - Samples 7 and 50 use golden=32'hFFFF_FFFF, netlist=32'hFFFF_FFFE.
  - mismatch_cnt=2, first_mm_idx=7, first_mm_golden=32'hFFFFFFFF, first_mm_netlist=32'hFFFFFFFE.
  - mm_pulse is high for exactly 2 single cycles; at the end fail=1, pass=0.
- Restart and ignore rules:
  - In RUN, after 40 samples, pulse start; the run continues and sample_cnt reaches 102 normally.
  - After DONE, start with simultaneous sample_vld; all statistics clear and sample_cnt=0 the next cycle.
- Saturation (CNT_W=4, NUM_SAMPLES=15, 15 mismatching samples):
  - mismatch_cnt stops at 15 with no wrap.
  - fail=1.
- Reset mid-run:
  - After 30 samples with 3 mismatches, drop rst.
  - State is IDLE and all counters/captures are 0; a fresh start and run behaves as in the all-match scenario.
